// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: size codes, responder states and
// byte-lane helpers used by the data-memory responder.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_e;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << {off[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Right-aligned store data is replicated so every candidate lane carries it.
    function automatic logic [31:0] store_steer(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   store_steer = {4{wdata[7:0]}};
            2'b01:   store_steer = {2{wdata[15:0]}};
            default: store_steer = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   load_extract = {24'h000000, sh[7:0]};
            F3_HU:   load_extract = {16'h0000, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the core datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_ram.sv
// Word-organised data array with byte-enable write and registered read that
// returns the word as it was before a same-edge write. Contents are not reset.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core's load/store port: one request at a time, fixed
// response latency, RV32I size/extension handling and fault reporting.
import riscv_pkg::*;

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_FIRST = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(LATENCY - 1);

    rsp_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_accept, w_req_ready, w_rsp_valid;
    logic          w_misalign, w_range_err, w_f3_err, w_err;
    logic [31:0]   w_ram_q;
    logic          r_load_ok, r_err;
    logic [1:0]    r_off;
    logic [2:0]    r_f3;

    assign w_misalign  = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0])
                      || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
    assign w_range_err = {2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS;
    assign w_f3_err    = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111})
                      || (bus.req_we && ((bus.req_funct3 == F3_BU) || (bus.req_funct3 == F3_HU)));
    assign w_err       = w_misalign || w_range_err || w_f3_err;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (w_accept && bus.req_we && !w_err),
        .i_be    (lane_mask(bus.req_funct3, bus.req_addr[1:0])),
        .i_addr  (bus.req_addr[AW+1:2]),
        .i_wdata (store_steer(bus.req_funct3, bus.req_wdata)),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_load_ok <= 1'b0;
            r_err     <= 1'b0;
            r_off     <= '0;
            r_f3      <= '0;
        end else if (w_accept) begin
            r_load_ok <= !bus.req_we && !w_err;
            r_err     <= w_err;
            r_off     <= bus.req_addr[1:0];
            r_f3      <= bus.req_funct3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = reset;
                w_accept    = bus.req_valid && reset;
                if (w_accept) begin
                    w_cnt_nxt   = CNT_FIRST;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) w_state_nxt = RESP;
                else                   w_cnt_nxt   = r_cnt + CW'(1);
            end
            RESP: begin
                w_rsp_valid = reset;
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The RAM read register only updates on accept, so extraction from it
    // stays stable for as long as the response is held.
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_err   = w_rsp_valid && r_err;
    assign bus.rsp_rdata = (w_rsp_valid && r_load_ok) ? load_extract(r_f3, r_off, w_ram_q) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=2 instance,
// plus hold, throughput (LATENCY=1 and 4) and reset sequences.
module tb_dmem_responder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_ready = 1'b0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if if_l2 ();
    dmem_responder_if if_l1 ();
    dmem_responder_if if_l4 ();

    assign if_l2.req_valid = req_valid;  assign if_l1.req_valid = req_valid;  assign if_l4.req_valid = req_valid;
    assign if_l2.req_we = req_we;        assign if_l1.req_we = req_we;        assign if_l4.req_we = req_we;
    assign if_l2.req_addr = req_addr;    assign if_l1.req_addr = req_addr;    assign if_l4.req_addr = req_addr;
    assign if_l2.req_wdata = req_wdata;  assign if_l1.req_wdata = req_wdata;  assign if_l4.req_wdata = req_wdata;
    assign if_l2.req_funct3 = req_funct3; assign if_l1.req_funct3 = req_funct3; assign if_l4.req_funct3 = req_funct3;
    assign if_l2.rsp_ready = rsp_ready;  assign if_l1.rsp_ready = rsp_ready;  assign if_l4.rsp_ready = rsp_ready;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (.clk(clk), .reset(reset), .bus(if_l2));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(if_l1));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut_l4 (.clk(clk), .reset(reset), .bus(if_l4));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Issue one request on the LATENCY=2 instance and return its response;
    // lat is the number of edges after the accept edge before rsp_valid is seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic [31:0] rd, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        rsp_ready = 1'b1;
        guard = 0;
        while (!if_l2.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!if_l2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = if_l2.rsp_rdata;
        err = if_l2.rsp_err;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          guard;
        int          acc1[$];
        int          acc4[$];
        logic        stale;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(if_l2.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(if_l2.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", if_l2.rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(if_l2.rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(if_l2.req_ready), 32'd1);

        vecs.push_back(mk(1'b1, 32'h10,  32'hDEADBEEF, F3_W,  32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_W,  32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h11,  32'h00000080, F3_B,  32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h11,  32'h0,        F3_B,  32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 32'h11,  32'h0,        F3_BU, 32'h00000080, 1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_W,  32'hDEAD80EF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13,  32'h0,        F3_H,  32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h12,  32'h0,        F3_W,  32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h400, 32'h12345678, F3_W,  32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        3'b011, 32'h0,       1'b1));
        vecs.push_back(mk(1'b1, 32'h10,  32'h0,        3'b011, 32'h0,       1'b1));
        vecs.push_back(mk(1'b1, 32'h10,  32'h0,        F3_HU, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h11,  32'h0,        F3_W,  32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_W,  32'hDEAD80EF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h12,  32'hA5A58001, F3_H,  32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h12,  32'h0,        F3_H,  32'hFFFF8001, 1'b0));
        vecs.push_back(mk(1'b0, 32'h12,  32'h0,        F3_HU, 32'h00008001, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13,  32'h0,        F3_B,  32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_BU, 32'h000000EF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_H,  32'hFFFF80EF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        F3_W,  32'h800180EF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h3FC, 32'hCAFEF00D, F3_W,  32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h3FC, 32'h0,        F3_W,  32'hCAFEF00D, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3FF, 32'h0,        F3_B,  32'hFFFFFFCA, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3FE, 32'h0,        F3_HU, 32'h0000CAFE, 1'b0));
        vecs.push_back(mk(1'b0, 32'h80000010, 32'h0,   F3_W,  32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h400, 32'h0,        F3_BU, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        3'b111, 32'h0,       1'b1));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        3'b110, 32'h0,       1'b1));

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, err, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Response held while rsp_ready stays low
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; rsp_ready = 1'b0;
        guard = 0;
        while (!if_l2.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!if_l2.rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rsp_valid", k), 32'(if_l2.rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", k), if_l2.rsp_rdata, 32'h800180EF);
            chk($sformatf("hold%0d_req_ready", k), 32'(if_l2.req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release_req_ready", 32'(if_l2.req_ready), 32'd1);
        chk("hold_release_rsp_valid", 32'(if_l2.rsp_valid), 32'd0);

        // Back-to-back throughput on the LATENCY=1 and LATENCY=4 instances
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_l1.req_ready) acc1.push_back(cyc);
            if (if_l4.req_ready) acc4.push_back(cyc);
        end
        req_valid = 1'b0;
        chk("tput_l1_count", 32'(acc1.size() >= 5), 32'd1);
        chk("tput_l4_count", 32'(acc4.size() >= 5), 32'd1);
        for (int k = 1; k < 5; k++) begin
            if (k < acc1.size()) chk($sformatf("tput_l1_gap%0d", k), 32'(acc1[k] - acc1[k-1]), 32'd2);
            if (k < acc4.size()) chk($sformatf("tput_l4_gap%0d", k), 32'(acc4[k] - acc4[k-1]), 32'd5);
        end
        repeat (8) @(negedge clk);

        // Reset during WAIT drops the in-flight load
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; rsp_ready = 1'b1;
        guard = 0;
        while (!if_l2.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_rsp_valid", 32'(if_l2.rsp_valid), 32'd0);
        chk("rst_wait_req_ready", 32'(if_l2.req_ready), 32'd0);
        chk("rst_wait_rsp_rdata", if_l2.rsp_rdata, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_req_ready", 32'(if_l2.req_ready), 32'd1);
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            stale = stale | if_l2.rsp_valid;
        end
        chk("rst_no_stale_rsp", 32'(stale), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, F3_W, rd, err, lat);
        chk("rst_mem_kept", rd, 32'h800180EF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
